// File: rtl/ifmap_window_mem_pkg.sv
// ifmap_pkg: shared sizes, types and helpers for the ifmap window store.
package ifmap_pkg;
   localparam int NUM_TS = 2;
   localparam int MAX_IF = 38;
   localparam int MAX_K  = 5;
   localparam int CHUNK  = 36;
   localparam int SZ_W   = 6;
   localparam int TS_W   = 1;
   typedef logic [MAX_K*MAX_K-1:0] window_t;
   typedef logic [MAX_IF-1:0][MAX_IF-1:0] plane_t;
   typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, REPORT = 2'd2} wr_state_e;
   function automatic logic [SZ_W-1:0] conv_size(input logic [SZ_W-1:0] n, input logic [2:0] k);
      return n - SZ_W'(k) + SZ_W'(1);
   endfunction
endpackage

// File: rtl/ifmap_window_mem_if.sv
// ifmap_window_mem_if: write-beat, window-read and conv-size handshakes.
interface ifmap_window_mem_if;
   import ifmap_pkg::*;
   logic            wr_valid, wr_ready, wr_last;
   logic [CHUNK-1:0] wr_data;
   logic [TS_W-1:0] wr_ts;
   logic [SZ_W-1:0] wr_if_size;
   logic [2:0]      wr_fil_k;
   logic            rd_req_valid, rd_req_ready, rd_valid, rd_ready;
   logic [SZ_W-1:0] rd_y, rd_x;
   logic [TS_W-1:0] rd_ts;
   window_t         rd_data;
   logic            cs_valid, cs_ready;
   logic [SZ_W-1:0] cs_data;
   modport master(output wr_valid, wr_data, wr_ts, wr_if_size, wr_fil_k, wr_last,
                  rd_req_valid, rd_y, rd_x, rd_ts, rd_ready, cs_ready,
                  input wr_ready, rd_req_ready, rd_valid, rd_data, cs_valid, cs_data);
   modport slave(input wr_valid, wr_data, wr_ts, wr_if_size, wr_fil_k, wr_last,
                 rd_req_valid, rd_y, rd_x, rd_ts, rd_ready, cs_ready,
                 output wr_ready, rd_req_ready, rd_valid, rd_data, cs_valid, cs_data);
endinterface

// File: rtl/ifmap_window_extract.sv
// ifmap_window_extract: KxK window at (y,x) of one plane, zero-padded past edge N.
module ifmap_window_extract
   import ifmap_pkg::*;
(
   input  plane_t          plane_i,
   input  logic [SZ_W-1:0] n_i,
   input  logic [SZ_W-1:0] y_i,
   input  logic [SZ_W-1:0] x_i,
   input  logic [2:0]      k_i,
   output window_t         win_o
);
   localparam int WW = $clog2(MAX_K*MAX_K);
   always_comb begin
      win_o = '0;
      for (int i = 0; i < MAX_K; i++)
         for (int j = 0; j < MAX_K; j++)
            if (i < int'(k_i) && j < int'(k_i) && int'(y_i) + i < int'(n_i) && int'(x_i) + j < int'(n_i))
               win_o[WW'(int'(k_i) * int'(k_i) - 1 - (i * int'(k_i) + j))] = plane_i[y_i + SZ_W'(i)][x_i + SZ_W'(j)];
   end
endmodule

// File: rtl/ifmap_window_mem.sv
// ifmap_window_mem: raster-loaded binary ifmap planes served as KxK windows,
// reporting the conv output size once every plane of a frame is in.
module ifmap_window_mem
   import ifmap_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   ifmap_window_mem_if.slave   bus,
   output logic [NUM_TS-1:0]   loaded_o,
   output logic                err_o
);
   wr_state_e         state_q, state_d;
   logic [SZ_W-1:0]   n_q, n_d, n_eff, n_m1, cy, cx;
   logic [2:0]        k_q, k_d, k_eff;
   logic [SZ_W-1:0]   py_q [NUM_TS], py_d [NUM_TS], px_q [NUM_TS], px_d [NUM_TS];
   logic [NUM_TS-1:0] loaded_q, loaded_d, base_loaded;
   logic              err_q, err_d, acc, first, drop, done, cfg_bad, rd_acc;
   logic              rd_valid_q, rd_valid_d;
   window_t           rd_data_q, rd_data_d, win;
   plane_t            mem_q [NUM_TS], mem_d [NUM_TS];

   assign bus.wr_ready     = state_q != REPORT;
   assign bus.cs_valid     = state_q == REPORT;
   assign bus.cs_data      = bus.cs_valid ? conv_size(n_q, k_q) : '0;
   assign bus.rd_req_ready = loaded_q[bus.rd_ts] && (!rd_valid_q || bus.rd_ready);
   assign bus.rd_valid     = rd_valid_q;
   assign bus.rd_data      = rd_data_q;
   assign loaded_o         = loaded_q;
   assign err_o            = err_q;

   always_comb begin
      acc         = bus.wr_valid && bus.wr_ready;
      first       = acc && state_q == IDLE;
      cfg_bad     = bus.wr_if_size > SZ_W'(MAX_IF) || bus.wr_fil_k < 3'd2 || bus.wr_fil_k > 3'(MAX_K);
      n_eff       = bus.wr_if_size > SZ_W'(MAX_IF) ? SZ_W'(MAX_IF) : bus.wr_if_size;
      k_eff       = bus.wr_fil_k < 3'd2 ? 3'd2 : bus.wr_fil_k > 3'(MAX_K) ? 3'(MAX_K) : bus.wr_fil_k;
      n_d         = first ? n_eff : n_q;
      k_d         = first ? k_eff : k_q;
      n_m1        = n_d - SZ_W'(1);
      base_loaded = first ? '0 : loaded_q;
      drop        = acc && base_loaded[bus.wr_ts];
      for (int t = 0; t < NUM_TS; t++) begin
         py_d[t] = first ? '0 : py_q[t];
         px_d[t] = first ? '0 : px_q[t];
      end
      mem_d = mem_q;
      cy    = py_d[bus.wr_ts];
      cx    = px_d[bus.wr_ts];
      done  = 1'b0;
      // bits past the plane's last position are discarded once done rises
      if (acc && !drop) begin
         for (int b = 0; b < CHUNK; b++)
            if (!done) begin
               mem_d[bus.wr_ts][cy][cx] = bus.wr_data[b];
               done = cx == n_m1 && cy == n_m1;
               cy   = cx == n_m1 ? cy + SZ_W'(1) : cy;
               cx   = cx == n_m1 ? '0 : cx + SZ_W'(1);
            end
         py_d[bus.wr_ts] = cy;
         px_d[bus.wr_ts] = cx;
      end
      loaded_d = base_loaded | (done ? NUM_TS'(1) << bus.wr_ts : '0);
      err_d    = err_q | (first && cfg_bad) | drop | (acc && !drop && bus.wr_last && !(&loaded_d));
      state_d  = bus.cs_valid && bus.cs_ready ? IDLE :
                 !acc ? state_q :
                 !drop && bus.wr_last && (&loaded_d) ? REPORT : LOAD;
   end

   ifmap_window_extract u_extract (
      .plane_i(mem_q[bus.rd_ts]),
      .n_i    (n_q),
      .y_i    (bus.rd_y),
      .x_i    (bus.rd_x),
      .k_i    (k_q),
      .win_o  (win)
   );

   always_comb begin
      rd_acc     = bus.rd_req_valid && bus.rd_req_ready;
      rd_valid_d = rd_acc || (rd_valid_q && !bus.rd_ready);
      rd_data_d  = rd_acc ? win : rd_data_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         n_q        <= '0;
         k_q        <= '0;
         loaded_q   <= '0;
         err_q      <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
         py_q       <= '{default: '0};
         px_q       <= '{default: '0};
         mem_q      <= '{default: '0};
      end else begin
         state_q    <= state_d;
         n_q        <= n_d;
         k_q        <= k_d;
         loaded_q   <= loaded_d;
         err_q      <= err_d;
         rd_valid_q <= rd_valid_d;
         rd_data_q  <= rd_data_d;
         py_q       <= py_d;
         px_q       <= px_d;
         mem_q      <= mem_d;
      end
   end
endmodule
